// File: rtl/sub_clk_sampler.sv
// rtl/sub_clk_sampler.sv - samples sub_data on rising edges of a clk-domain divided clock, with stall detection
// Optional sequence checker enabled by defining SUB_CLK_SAMPLER_SEQCHK_EN.
module sub_clk_sampler #(
  parameter int WIDTH   = 2,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 8,
  parameter int DSTEP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sub_clk,
  input  logic [WIDTH-1:0] sub_data,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             stall,
  output logic             seq_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  localparam logic [7:0] TO_FULL = 8'(TIMEOUT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       sc_q;
  logic [7:0] idle_cnt;
  logic       rise;

  // sub_clk is plain data here; a rise is a 0->1 step across one clk cycle
  assign rise = sub_clk & ~sc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sc_q      <= 1'b0;
      idle_cnt  <= 8'd0;
      res       <= '0;
      res_valid <= 1'b0;
      edge_cnt  <= '0;
      stall     <= 1'b0;
    end else begin
      sc_q      <= sub_clk;
      res_valid <= rise;
      if (rise) begin
        res      <= sub_data;
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          idle_cnt <= 8'd0;
          if (rise) state <= RUN;
        end
        RUN: begin
          // a rise on the timeout cycle wins and keeps the block running
          if (rise) begin
            idle_cnt <= 8'd0;
          end else if (idle_cnt == TO_LAST) begin
            idle_cnt <= TO_FULL;
            state    <= STALL;
            stall    <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        STALL: begin
          if (rise) begin
            idle_cnt <= 8'd0;
            state    <= RUN;
            stall    <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          idle_cnt <= 8'd0;
          stall    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUB_CLK_SAMPLER_SEQCHK_EN
  logic [WIDTH-1:0] expect_data;

  assign expect_data = res + WIDTH'(DSTEP);

  // only RUN implies a prior capture; rises in IDLE or STALL just seed res
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      seq_err <= 1'b0;
      if (rise && state == RUN && sub_data != expect_data) begin
        seq_err <= 1'b1;
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sub_clk_sampler.sv
// tb/tb_sub_clk_sampler.sv - self-checking bench for sub_clk_sampler (default and CNT_W=2 instances)
module tb_sub_clk_sampler;

`ifdef SUB_CLK_SAMPLER_SEQCHK_EN
  localparam bit SEQCHK = 1'b1;
`else
  localparam bit SEQCHK = 1'b0;
`endif
  localparam int TIMEOUT = 8;
  localparam int DSTEP   = 2;

  logic       clk;
  logic       reset;
  logic       sub_clk;
  logic [1:0] sub_data;
  logic [1:0] res, res2;
  logic       res_valid, res_valid2;
  logic [7:0] edge_cnt, err_cnt;
  logic [1:0] edge_cnt2, err_cnt2;
  logic       stall, stall2, seq_err, seq_err2;

  sub_clk_sampler dut (
    .clk(clk), .reset(reset), .sub_clk(sub_clk), .sub_data(sub_data),
    .res(res), .res_valid(res_valid), .edge_cnt(edge_cnt), .stall(stall),
    .seq_err(seq_err), .err_cnt(err_cnt)
  );

  sub_clk_sampler #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .sub_clk(sub_clk), .sub_data(sub_data),
    .res(res2), .res_valid(res_valid2), .edge_cnt(edge_cnt2), .stall(stall2),
    .seq_err(seq_err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: time-based, counts kept as unbounded integers
  int m_cyc = 0, m_prev = 0, m_started = 0, m_last_rise = 0;
  int m_res = 0, m_edges = 0, m_errs = 0;
  int m_valid = 0, m_stall = 0, m_serr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input bit r, input bit sc, input int d);
    bit rise;
    m_cyc++;
    if (r) begin
      m_prev = 0; m_started = 0; m_res = 0; m_edges = 0; m_errs = 0;
      m_valid = 0; m_stall = 0; m_serr = 0;
      return;
    end
    rise = sc && (m_prev == 0);
    m_prev = sc;
    m_valid = rise;
    m_serr = 0;
    if (rise) begin
      if (SEQCHK && m_started != 0 && m_stall == 0 && d != (m_res + DSTEP) % 4) begin
        m_serr = 1;
        m_errs++;
      end
      m_res = d;
      m_edges++;
      m_started = 1;
      m_last_rise = m_cyc;
      m_stall = 0;
    end else begin
      m_stall = (m_started != 0 && (m_cyc - m_last_rise) >= TIMEOUT) ? 1 : 0;
    end
  endtask

  task automatic step(input bit r, input bit sc, input int d);
    reset = r;
    sub_clk = sc;
    sub_data = 2'(d);
    @(posedge clk);
    model(r, sc, d);
    #1;
    chk("res", res, m_res);
    chk("res_valid", res_valid, m_valid);
    chk("edge_cnt", edge_cnt, m_edges % 256);
    chk("stall", stall, m_stall);
    chk("seq_err", seq_err, m_serr);
    chk("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
    chk("edge_cnt2", edge_cnt2, m_edges % 4);
    chk("err_cnt2", err_cnt2, (m_errs > 3) ? 3 : m_errs);
    chk("stall2", stall2, m_stall);
  endtask

  typedef struct {
    bit r; bit sc; int d;
    int e_res; bit e_valid; int e_edge; bit e_stall;
  } vec_t;

  vec_t tbl[12];
  int   edge_exp[5];
  int   pulses;
  int   d;
  int   mode, len;

  initial begin
    clk = 0; reset = 1; sub_clk = 0; sub_data = 0;
    tbl[0]  = '{1, 1, 3, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 1, 1, 0};
    tbl[3]  = '{0, 0, 2, 1, 0, 1, 0};
    tbl[4]  = '{0, 1, 3, 3, 1, 2, 0};
    tbl[5]  = '{0, 0, 0, 3, 0, 2, 0};
    tbl[6]  = '{0, 1, 1, 1, 1, 3, 0};
    tbl[7]  = '{0, 1, 2, 1, 0, 3, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 3, 0};
    tbl[9]  = '{0, 1, 3, 3, 1, 4, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 1, 1, 1, 0};
    edge_exp = '{1, 2, 3, 0, 1};

    step(1, 0, 0);
    step(1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].sc, tbl[i].d);
      chk($sformatf("tbl%0d_res", i), res, tbl[i].e_res);
      chk($sformatf("tbl%0d_valid", i), res_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_edge", i), edge_cnt, tbl[i].e_edge);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_seq_err", i), seq_err, 0);
    end

    // data stream slips by one sample at k=7: exactly one mismatch
    step(1, 0, 0);
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      step(0, k % 2, (k >= 7) ? (k + 2) % 4 : k % 4);
      if (seq_err === 1'b1) pulses++;
    end
    chk("slip_pulses", pulses, SEQCHK ? 1 : 0);
    chk("slip_err_cnt", err_cnt, SEQCHK ? 1 : 0);

    // stall after TIMEOUT quiet cycles, cleared by the next rise without a check
    step(1, 0, 0);
    step(0, 1, 2);
    for (int i = 1; i < TIMEOUT; i++) begin
      step(0, 0, 0);
      chk("stall_early", stall, 0);
    end
    step(0, 0, 0);
    chk("stall_at_timeout", stall, 1);
    step(0, 0, 0);
    chk("stall_held", stall, 1);
    step(0, 1, 3);
    chk("stall_clear", stall, 0);
    chk("stall_reseed_res", res, 3);
    chk("stall_reseed_valid", res_valid, 1);
    chk("stall_reseed_seq_err", seq_err, 0);

    // rise on the timeout cycle keeps RUN and restarts the idle count
    step(1, 0, 0);
    step(0, 1, 1);
    for (int i = 1; i < TIMEOUT; i++) step(0, 0, 0);
    step(0, 1, 3);
    chk("race_stall", stall, 0);
    chk("race_valid", res_valid, 1);
    for (int i = 1; i < TIMEOUT; i++) begin
      step(0, 0, 0);
      chk("race_idle_restart", stall, 0);
    end
    step(0, 0, 0);
    chk("race_late_stall", stall, 1);

    // CNT_W=2 wrap and saturation with constant data (every later rise mismatches)
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0);
      if (i < 5) chk($sformatf("wrap_edge%0d", i), edge_cnt2, edge_exp[i]);
      step(0, 0, 0);
    end
    chk("sat_err_cnt2", err_cnt2, SEQCHK ? 3 : 0);
    chk("sat_err_cnt", err_cnt, SEQCHK ? 5 : 0);

    // randomized segments against the model
    step(1, 0, 0);
    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 3);
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        d = ($urandom_range(0, 1) != 0) ? (m_res + DSTEP) % 4 : $urandom_range(0, 3);
        case (mode)
          0: step(0, j % 2, d);
          1: step(0, 0, d);
          2: step(0, 1, d);
          default: step($urandom_range(0, 15) == 0, $urandom_range(0, 1), d);
        endcase
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sub_clk_sampler.md
SUB_CLK_SAMPLER -- requirements
Module: sub_clk_sampler

Interface
REQ-001 Parameter WIDTH, default 2: width of the sampled data bus.
REQ-002 Parameter CNT_W, default 8: width of the edge and error counters.
REQ-003 Parameter TIMEOUT, default 8: clk cycles without a sub_clk rising edge before the block declares a stall; legal range 2..255.
REQ-004 Parameter DSTEP, default 2: expected increment of sub_data between consecutive captures, modulo 2^WIDTH.
REQ-005 Port clk, input, 1: the single clock; all logic samples on posedge clk.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port sub_clk, input, 1: divided clock produced in the clk domain; treated as data, never used as a clock.
REQ-008 Port sub_data, input, WIDTH: data qualified by sub_clk rising edges.
REQ-009 Port res, output, WIDTH: last captured sub_data.
REQ-010 Port res_valid, output, 1: one-cycle pulse when res updates.
REQ-011 Port edge_cnt, output, CNT_W: count of rising edges detected.
REQ-012 Port stall, output, 1: high while in state STALL.
REQ-013 Port seq_err, output, 1: one-cycle pulse on a sequence mismatch.
REQ-014 Port err_cnt, output, CNT_W: count of sequence mismatches.

Function
REQ-015 The block SHALL register sub_clk into sc_q each cycle; a rise SHALL be defined as sub_clk=1 and sc_q=0 in the same cycle.
REQ-016 On a rise, the block SHALL load res with that cycle's sub_data and pulse res_valid high at the next posedge, giving 1-cycle latency.
REQ-017 edge_cnt SHALL increment by 1 on every rise and wrap from 2^CNT_W-1 to 0.
REQ-018 The FSM SHALL have states IDLE, RUN and STALL: IDLE->RUN on the first rise; RUN->STALL when idle_cnt reaches TIMEOUT; STALL->RUN on a rise.
REQ-019 idle_cnt SHALL clear on a rise, increment each cycle without a rise in RUN, saturate at TIMEOUT, and stay 0 in IDLE (IDLE never times out).
REQ-020 If a rise and the TIMEOUT condition fall in the same cycle, the rise SHALL win: state stays RUN and idle_cnt clears.
REQ-021 stall SHALL be high exactly while the state is STALL.
REQ-022 A rise in RUN with a prior capture SHALL compare sub_data with (res + DSTEP) mod 2^WIDTH; on mismatch, seq_err SHALL pulse for one cycle aligned with res_valid.
REQ-023 The first capture after IDLE or STALL SHALL seed res without a comparison.
REQ-024 err_cnt SHALL increment on each seq_err and saturate at 2^CNT_W-1.

Reset
REQ-025 While reset is high at a posedge: state SHALL be IDLE; res, edge_cnt, err_cnt and idle_cnt SHALL be 0; res_valid, seq_err and stall SHALL be 0; sc_q SHALL be 0.
REQ-026 Reset SHALL take priority over a rise in the same cycle; no capture and no count occur.
REQ-027 After reset deasserts, sub_clk=1 in the first cycle SHALL count as a rise, because sc_q=0.

Configuration
REQ-028 With macro SUB_CLK_SAMPLER_SEQCHK_EN defined, the block SHALL include the sequence checker (REQ-022 to REQ-024).
REQ-029 Without SUB_CLK_SAMPLER_SEQCHK_EN, seq_err and err_cnt SHALL be tied to 0 and no comparison logic SHALL be built; all other behaviour is unchanged.

Verification
REQ-030 Defaults, reset released, sub_clk toggling every cycle from 0, sub_data = 0,1,2,3,... mod 4 per cycle -> res_valid every 2nd cycle, res = 1,3,1,3..., edge_cnt +1 per pulse, seq_err never, stall never.
REQ-031 Same pattern but sub_data held at 1 for one rise -> exactly one seq_err pulse, err_cnt=1; with the macro undefined, err_cnt stays 0.
REQ-032 After a rise, hold sub_clk=0 for 8 cycles -> stall rises 8 cycles after the last rise; the next rise clears stall, res loads, and no seq_err fires regardless of data.
REQ-033 Rise occurs on the cycle idle_cnt would reach TIMEOUT -> stall stays 0 and idle_cnt clears.
REQ-034 Assert reset for 1 cycle mid-stream while sub_clk=1 -> all outputs 0 and state IDLE; the next rise seeds res without a seq_err.
REQ-035 CNT_W=2 with 5 rises -> edge_cnt = 1,2,3,0,1; 5 forced mismatches -> err_cnt saturates at 3.
